// File: rtl/adc_address_sequencer_if.sv
// Signal bundle between the ADC front-end controller and the address sequencer.
// The master drives the converter-side inputs; the slave (sequencer) returns address, CLK1 and debug state.
interface adc_address_sequencer_if #(
    parameter int ADDR_W = 3
);
    // init and OE_R are free-running levels with no handshake.
    // Each one acts once, on its synchronized rising edge.
    logic              init;
    logic              OE_R;
    logic [ADDR_W-1:0] add_o;
    logic              CLK1;
    logic              dbg_scan;

    modport master (
        output init,
        output OE_R,
        input  add_o,
        input  CLK1,
        input  dbg_scan
    );

    modport slave (
        input  init,
        input  OE_R,
        output add_o,
        output CLK1,
        output dbg_scan
    );
endinterface

// File: rtl/adc_address_sequencer.sv
// ADC0808-style support block: divides CLK down to CLK1 and steps the mux channel address
// through 0..NUM_CH-1 once per init request, advancing on each synchronized OE_R rise.
module adc_address_sequencer #(
    parameter int CLK_DIV = 25,
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 3
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    adc_address_sequencer_if.slave  bus
);

    generate
        if (CLK_DIV < 1 || CLK_DIV > 65535) begin : g_bad_div
            $error("adc_address_sequencer: CLK_DIV out of range 1..65535");
        end
        if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
            $error("adc_address_sequencer: NUM_CH out of range 1..8");
        end
        if (ADDR_W != 3) begin : g_bad_w
            $error("adc_address_sequencer: ADDR_W must be 3");
        end
    endgenerate

    localparam logic [15:0]       DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_CH  = ADDR_W'(NUM_CH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] add_q;
    logic [15:0]       div_cnt;
    logic              clk1_q;

    logic init_s1, init_s2, init_d;
    logic oe_s1, oe_s2, oe_d;
    logic init_rise;
    logic oe_rise;

    // Free-running divider; CLK1 is unrelated to scan state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt <= 16'd0;
            clk1_q  <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= 16'd0;
            clk1_q  <= ~clk1_q;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            init_s1 <= 1'b0;
            init_s2 <= 1'b0;
            init_d  <= 1'b0;
            oe_s1   <= 1'b0;
            oe_s2   <= 1'b0;
            oe_d    <= 1'b0;
        end else begin
            init_s1 <= bus.init;
            init_s2 <= init_s1;
            init_d  <= init_s2;
            oe_s1   <= bus.OE_R;
            oe_s2   <= oe_s1;
            oe_d    <= oe_s2;
        end
    end

    assign init_rise = init_s2 & ~init_d;
    assign oe_rise   = oe_s2 & ~oe_d;

    // In IDLE a simultaneous OE_R rise is dropped, so start always wins.
    // In SCAN any count at or beyond the last channel ends the scan, which also recovers upset values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            add_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (init_rise) begin
                        state <= SCAN;
                        add_q <= '0;
                    end
                end
                SCAN: begin
                    if (oe_rise) begin
                        if (add_q >= LAST_CH) begin
                            state <= IDLE;
                            add_q <= '0;
                        end else begin
                            add_q <= add_q + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    add_q <= '0;
                end
            endcase
        end
    end

    assign bus.add_o    = add_q;
    assign bus.CLK1     = clk1_q;
    assign bus.dbg_scan = (state == SCAN);

endmodule

// File: tb/tb_adc_address_sequencer.sv
// Directed bench for adc_address_sequencer with CLK_DIV=2, NUM_CH=4: vector tables per scenario
// plus hand-written sequences for reset, CLK1 timing and sub-cycle glitches.
module tb_adc_address_sequencer;

  localparam int CLK_DIV = 2;
  localparam int NUM_CH  = 4;

  logic CLK;
  logic RST_N;

  adc_address_sequencer_if #(.ADDR_W(3)) bus ();

  adc_address_sequencer #(
    .CLK_DIV(CLK_DIV),
    .NUM_CH (NUM_CH),
    .ADDR_W (3)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus.slave)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic       init;
    logic       oe_r;
    logic [2:0] exp_add;
    logic       exp_act;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_err;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One record per CLK cycle. Records 0 and 1 of a pulse expect the old values.
  // From record 2 on they expect the new values, because the synchronizer acts two edges after sampling.
  task automatic add_pulse(input logic init_hi, input logic init_lo, input logic oe_hi,
                           input int high, input int low,
                           input logic [2:0] add_before, input logic [2:0] add_after,
                           input logic act_before, input logic act_after);
    vec_t v;
    for (int j = 0; j < high + low; j++) begin
      v.init    = (j < high) ? init_hi : init_lo;
      v.oe_r    = (j < high) ? oe_hi : 1'b0;
      v.exp_add = (j >= 2) ? add_after : add_before;
      v.exp_act = (j >= 2) ? act_after : act_before;
      vecs.push_back(v);
    end
  endtask

  // Drive at a falling edge and check at the next falling edge.
  task automatic run_vectors(input string tag);
    foreach (vecs[i]) begin
      bus.init = vecs[i].init;
      bus.OE_R = vecs[i].oe_r;
      @(negedge CLK);
      check({tag, "_add"}, int'(bus.add_o), int'(vecs[i].exp_add));
      check({tag, "_act"}, int'(bus.dbg_scan), int'(vecs[i].exp_act));
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    bus.init = 1'b0;
    bus.OE_R = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_add", int'(bus.add_o), 0);
    check("rst_clk1", int'(bus.CLK1), 0);
    check("rst_act", int'(bus.dbg_scan), 0);
    RST_N = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RST_N = 1'b0;
    bus.init = 1'b0;
    bus.OE_R = 1'b0;

    // 1: CLK1 after release. Edge n gives CLK1 = (n / CLK_DIV) odd.
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      check("clk1_div", int'(bus.CLK1), ((n / CLK_DIV) % 2));
      check("clk1_add", int'(bus.add_o), 0);
    end

    // 2: full scan, then extra OE_R pulses while idle
    add_pulse(1, 0, 0, 4, 4, 0, 0, 0, 1);
    add_pulse(0, 0, 1, 3, 5, 0, 1, 1, 1);
    add_pulse(0, 0, 1, 3, 5, 1, 2, 1, 1);
    add_pulse(0, 0, 1, 3, 5, 2, 3, 1, 1);
    add_pulse(0, 0, 1, 3, 5, 3, 0, 1, 0);
    add_pulse(0, 0, 1, 3, 5, 0, 0, 0, 0);
    add_pulse(0, 0, 1, 3, 5, 0, 0, 0, 0);
    run_vectors("scan");

    // 3: OE_R without init, then init held high through 8 pulses gives one scan only
    do_reset();
    add_pulse(0, 0, 1, 3, 5, 0, 0, 0, 0);
    add_pulse(0, 0, 1, 3, 5, 0, 0, 0, 0);
    add_pulse(1, 1, 0, 3, 1, 0, 0, 0, 1);
    add_pulse(1, 1, 1, 3, 5, 0, 1, 1, 1);
    add_pulse(1, 1, 1, 3, 5, 1, 2, 1, 1);
    add_pulse(1, 1, 1, 3, 5, 2, 3, 1, 1);
    add_pulse(1, 1, 1, 3, 5, 3, 0, 1, 0);
    for (int p = 0; p < 4; p++) add_pulse(1, 1, 1, 3, 5, 0, 0, 0, 0);
    add_pulse(0, 0, 0, 4, 0, 0, 0, 0, 0);
    add_pulse(1, 0, 0, 4, 4, 0, 0, 0, 1);
    add_pulse(0, 0, 1, 3, 5, 0, 1, 1, 1);
    add_pulse(0, 0, 1, 3, 5, 1, 2, 1, 1);
    run_vectors("hold");

    // 4: asynchronous reset mid-scan at add_o=2
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("async_add", int'(bus.add_o), 0);
    check("async_clk1", int'(bus.CLK1), 0);
    check("async_act", int'(bus.dbg_scan), 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    add_pulse(0, 0, 1, 3, 5, 0, 0, 0, 0);
    add_pulse(0, 0, 1, 3, 5, 0, 0, 0, 0);
    run_vectors("post_rst");

    // 5: init and OE_R rise together while idle, so start wins
    add_pulse(1, 0, 1, 3, 5, 0, 0, 0, 1);
    add_pulse(0, 0, 1, 3, 5, 0, 1, 1, 1);
    run_vectors("simul");

    // 6: sub-cycle glitch between edges is missed; a 2-cycle pulse gives exactly one step
    @(posedge CLK);
    #2 bus.OE_R = 1'b1;
    #2 bus.OE_R = 1'b0;
    repeat (5) @(negedge CLK);
    check("glitch_add", int'(bus.add_o), 1);
    check("glitch_act", int'(bus.dbg_scan), 1);
    add_pulse(0, 0, 1, 2, 5, 1, 2, 1, 1);
    run_vectors("short");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
